morra_cinese_param: RTL and testbench
=====================================

Name: morra_cinese_param

Overview:
- Parametrised rock-paper-scissors (morra cinese) game engine for two players.
- Successor to the fixed MorraCinese FSMD.
- Adds the following over the fixed engine:
  - configurable minimum manche count;
  - per-game maximum manche count, loaded at start;
  - configurable winning margin;
  - an optional no-repeat-winning-move rule;
  - a played-manche counter output.
- Sits between player input logic and the score display; all outputs are registered.

Parameters:
- MIN_MANCHE, default 4: manches that must be played before a lead can end the game.
- CFG_W, default 4: width of CFG. Maximum manches per game = MIN_MANCHE + CFG.
- LEAD, default 2: winning margin. Once at least MIN_MANCHE manches are played, a lead of LEAD or more ends the game.
- NO_REPEAT, default 1: 1 enables the rule that a manche winner may not replay their winning move in the next manche.
- CNT_W is derived, not settable: clog2(MIN_MANCHE + 2**CFG_W + 1).

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: synchronous active-high reset.
- INIZIA, input, 1: start or restart a game; samples CFG.
- CFG, input, CFG_W: extra manches beyond MIN_MANCHE for this game.
- PRIMO, input, 2: player 1 move. 00 = none, 01 = sasso, 10 = carta, 11 = forbice.
- SECONDO, input, 2: player 2 move, same encoding as PRIMO.
- MANCHE, output, 2: last manche result. 00 = invalid/none, 01 = P1 won, 10 = P2 won, 11 = draw.
- PARTITA, output, 2: game result. 00 = in progress/idle, 01 = P1 won, 10 = P2 won, 11 = draw.
- NUM_MANCHE, output, CNT_W: valid manches played in the current game.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - rst high at an edge sets MANCHE=00, PARTITA=00, NUM_MANCHE=0.
  - Clears the score difference and last-winner info; state goes to IDLE.
  - rst has priority over INIZIA.
- FSM states:
  - IDLE: moves are ignored; MANCHE=00.
  - PLAY: every cycle is one manche attempt.
  - END: PARTITA is held; MANCHE=00; moves are ignored.
- INIZIA=1, in any state, rst low:
  - MAXM <= MIN_MANCHE + CFG; NUM_MANCHE <= 0; diff <= 0; last-winner cleared.
  - MANCHE <= 00, PARTITA <= 00; go to PLAY.
  - The moves presented in the INIZIA cycle are not played.
- Latency: inputs sampled at edge k give outputs visible after edge k (one register stage).
- Manche validity in PLAY. The attempt is invalid, with MANCHE <= 00 and no other state change, if either:
  - PRIMO==00 or SECONDO==00; or
  - NO_REPEAT=1 and the previous manche winner presents the same move they won with.
- After a draw, no move is banned.
- Valid manche:
  - Beats relation: sasso>forbice, forbice>carta, carta>sasso; equal moves = draw (11).
  - NUM_MANCHE increments by 1.
  - diff (signed, range ±MAXM) changes by +1 on a P1 win, -1 on a P2 win, 0 on a draw.
  - Last-winner and winning move are updated; a draw clears them.
- End check, evaluated on the post-update values in the same cycle:
  - If NUM_MANCHE ≥ MIN_MANCHE and |diff| ≥ LEAD, then PARTITA <= winner (01 or 10) and go to END.
  - Else if NUM_MANCHE == MAXM, then PARTITA <= 01 if diff>0, 10 if diff<0, 11 if diff==0, and go to END.
  - MANCHE shows the deciding manche's result in that same cycle.
- END:
  - MANCHE <= 00 from the next cycle on.
  - PARTITA and NUM_MANCHE hold until INIZIA or rst.
- Boundary cases:
  - Invalid attempts never count toward MAXM.
  - CFG=0 gives MAXM=MIN_MANCHE.
  - CFG changes outside INIZIA cycles are ignored.
  - INIZIA mid-game aborts the current game with no result reported.

Test Plan:
- Reset: rst=1 for 2 cycles, then PRIMO=01/SECONDO=11 without INIZIA -> MANCHE=00, PARTITA=00, NUM_MANCHE=0 throughout.
- P1 sweep (CFG=0):
  - Stimulus: INIZIA, then 01v11, 10v01, 11v10, 01v11.
  - Each manche -> MANCHE=01.
  - After the 4th -> PARTITA=01, NUM_MANCHE=4; a further 10v01 -> MANCHE=00, state unchanged.
- No-repeat rule:
  - NO_REPEAT=1: P1 wins 01v11, then plays 01v10 -> MANCHE=00, NUM_MANCHE stays 1.
  - NO_REPEAT=0 instance, same stimulus -> MANCHE=10, NUM_MANCHE=2.
- Draw game (CFG=0): four 10v10 manches -> MANCHE=11 each; PARTITA=11 after the 4th; NUM_MANCHE=4.
- Max-manche decision (CFG=2, MAXM=6):
  - Sequence: P1 win, P2 win, P1 win, P2 win, P1 win, draw.
  - PARTITA stays 00 through the 5th manche; after the 6th -> PARTITA=01, NUM_MANCHE=6.
- Restart and priority:
  - rst and INIZIA high in the same cycle -> IDLE, outputs 0.
  - INIZIA in END -> PARTITA=00, NUM_MANCHE=0 next cycle.
  - The next valid manche -> NUM_MANCHE=1.

Source files
------------

// File: rtl/morra_cinese_param.sv
// Parametrised two-player rock-paper-scissors engine: plays one manche per cycle,
// tracks the score difference and declares the game on lead or on the per-game manche limit.
module morra_cinese_param #(
  parameter int  MIN_MANCHE = 4,
  parameter int  CFG_W      = 4,
  parameter int  LEAD       = 2,
  parameter int  NO_REPEAT  = 1,
  localparam int CNT_W      = $clog2(MIN_MANCHE + 2**CFG_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             INIZIA,
  input  logic [CFG_W-1:0] CFG,
  input  logic [1:0]       PRIMO,
  input  logic [1:0]       SECONDO,
  output logic [1:0]       MANCHE,
  output logic [1:0]       PARTITA,
  output logic [CNT_W-1:0] NUM_MANCHE
);

  // One extra bit so the signed difference covers +/- the largest manche limit.
  localparam int DW = CNT_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;

  localparam logic [1:0] R_NONE = 2'b00;
  localparam logic [1:0] R_P1   = 2'b01;
  localparam logic [1:0] R_P2   = 2'b10;
  localparam logic [1:0] R_DRAW = 2'b11;

  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_MANCHE);
  localparam logic [DW-1:0]    LEAD_V = DW'(LEAD);

  logic [1:0]              state_reg, state_next;
  logic [CNT_W-1:0]        maxm_reg, maxm_next;
  logic [CNT_W-1:0]        num_reg, num_next;
  logic signed [DW-1:0]    diff_reg, diff_next;
  logic [1:0]              last_win_reg, last_win_next;
  logic [1:0]              win_move_reg, win_move_next;
  logic [1:0]              manche_reg, manche_next;
  logic [1:0]              partita_reg, partita_next;

  logic [1:0]              result;
  logic                    banned;
  logic                    valid;
  logic [CNT_W-1:0]        num_upd;
  logic signed [DW-1:0]    diff_upd;
  logic [DW-1:0]           diff_mag;
  logic [1:0]              sign_result;
  logic                    lead_hit;
  logic                    max_hit;

  always_comb begin
    if (PRIMO == SECONDO) begin
      result = R_DRAW;
    end else if ((PRIMO == 2'b01 && SECONDO == 2'b11) ||
                 (PRIMO == 2'b11 && SECONDO == 2'b10) ||
                 (PRIMO == 2'b10 && SECONDO == 2'b01)) begin
      result = R_P1;
    end else begin
      result = R_P2;
    end
  end

  // Only the previous winner is restricted, and only to the move they won with.
  assign banned = (NO_REPEAT != 0) &&
                  ((last_win_reg == R_P1 && PRIMO   == win_move_reg) ||
                   (last_win_reg == R_P2 && SECONDO == win_move_reg));
  assign valid  = (PRIMO != 2'b00) && (SECONDO != 2'b00) && !banned;

  assign num_upd = num_reg + CNT_W'(1);

  always_comb begin
    diff_upd = diff_reg;
    if (result == R_P1) begin
      diff_upd = diff_reg + DW'(1);
    end else if (result == R_P2) begin
      diff_upd = diff_reg - DW'(1);
    end
  end

  assign diff_mag    = diff_upd[DW-1] ? (~diff_upd + DW'(1)) : diff_upd;
  assign sign_result = (diff_upd == '0) ? R_DRAW : (diff_upd[DW-1] ? R_P2 : R_P1);
  assign lead_hit    = (num_upd >= MIN_V) && (diff_mag >= LEAD_V);
  assign max_hit     = (num_upd == maxm_reg);

  always_comb begin
    state_next    = state_reg;
    maxm_next     = maxm_reg;
    num_next      = num_reg;
    diff_next     = diff_reg;
    last_win_next = last_win_reg;
    win_move_next = win_move_reg;
    manche_next   = R_NONE;
    partita_next  = partita_reg;
    if (INIZIA) begin
      state_next    = S_PLAY;
      maxm_next     = MIN_V + CNT_W'(CFG);
      num_next      = '0;
      diff_next     = '0;
      last_win_next = R_NONE;
      win_move_next = 2'b00;
      partita_next  = R_NONE;
    end else if (state_reg == S_PLAY && valid) begin
      manche_next = result;
      num_next    = num_upd;
      diff_next   = diff_upd;
      if (result == R_DRAW) begin
        last_win_next = R_NONE;
        win_move_next = 2'b00;
      end else begin
        last_win_next = result;
        win_move_next = (result == R_P1) ? PRIMO : SECONDO;
      end
      if (lead_hit || max_hit) begin
        partita_next = sign_result;
        state_next   = S_END;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      maxm_reg     <= '0;
      num_reg      <= '0;
      diff_reg     <= '0;
      last_win_reg <= R_NONE;
      win_move_reg <= 2'b00;
      manche_reg   <= R_NONE;
      partita_reg  <= R_NONE;
    end else begin
      state_reg    <= state_next;
      maxm_reg     <= maxm_next;
      num_reg      <= num_next;
      diff_reg     <= diff_next;
      last_win_reg <= last_win_next;
      win_move_reg <= win_move_next;
      manche_reg   <= manche_next;
      partita_reg  <= partita_next;
    end
  end

  assign MANCHE     = manche_reg;
  assign PARTITA    = partita_reg;
  assign NUM_MANCHE = num_reg;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Bench for morra_cinese_param: a directed vector table, then random play checked against
// a score-counting model, on two instances that differ only in the no-repeat rule.
module tb_morra_cinese_param;

  localparam int MIN_M = 4;
  localparam int LEAD_M = 2;

  logic       clk;
  logic       rst;
  logic       inizia;
  logic [3:0] cfg;
  logic [1:0] primo;
  logic [1:0] secondo;
  logic [1:0] manche_a, partita_a, manche_b, partita_b;
  logic [4:0] num_a, num_b;

  int total = 0;
  int bad = 0;

  morra_cinese_param #(.NO_REPEAT(1)) dut_a (
    .clk(clk), .rst(rst), .INIZIA(inizia), .CFG(cfg), .PRIMO(primo), .SECONDO(secondo),
    .MANCHE(manche_a), .PARTITA(partita_a), .NUM_MANCHE(num_a)
  );

  morra_cinese_param #(.NO_REPEAT(0)) dut_b (
    .clk(clk), .rst(rst), .INIZIA(inizia), .CFG(cfg), .PRIMO(primo), .SECONDO(secondo),
    .MANCHE(manche_b), .PARTITA(partita_b), .NUM_MANCHE(num_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int r; int ini; int cfg; int p; int s;
    int ma; int pa; int na;
    int mb; int pb; int nb;
  } vec_t;

  vec_t vq[$];

  // Model state, index 0 = no-repeat instance, 1 = free instance.
  // phase: 0 idle, 1 playing, 2 finished.
  int m_phase[2], m_maxm[2], m_p1w[2], m_p2w[2], m_dr[2];
  int m_lastw[2], m_lastmv[2], m_man[2], m_par[2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear(input int k);
    m_p1w[k] = 0; m_p2w[k] = 0; m_dr[k] = 0;
    m_lastw[k] = 0; m_lastmv[k] = 0;
    m_man[k] = 0; m_par[k] = 0;
  endtask

  task automatic model_step(input int k, input int r, input int ini, input int c,
                            input int p, input int s);
    int o, played, lead;
    bit blocked;
    if (r != 0) begin
      m_phase[k] = 0;
      model_clear(k);
    end else if (ini != 0) begin
      m_phase[k] = 1;
      m_maxm[k] = MIN_M + c;
      model_clear(k);
    end else begin
      m_man[k] = 0;
      blocked = (k == 0) && ((m_lastw[k] == 1 && p == m_lastmv[k]) ||
                             (m_lastw[k] == 2 && s == m_lastmv[k]));
      if (m_phase[k] == 1 && p != 0 && s != 0 && !blocked) begin
        o = (((p - s) % 3) + 3) % 3;
        if (o == 1) begin
          m_p1w[k]++; m_man[k] = 1; m_lastw[k] = 1; m_lastmv[k] = p;
        end else if (o == 2) begin
          m_p2w[k]++; m_man[k] = 2; m_lastw[k] = 2; m_lastmv[k] = s;
        end else begin
          m_dr[k]++; m_man[k] = 3; m_lastw[k] = 0; m_lastmv[k] = 0;
        end
        played = m_p1w[k] + m_p2w[k] + m_dr[k];
        lead = m_p1w[k] - m_p2w[k];
        if ((played >= MIN_M && (lead >= LEAD_M || -lead >= LEAD_M)) || played == m_maxm[k]) begin
          m_phase[k] = 2;
          m_par[k] = (lead > 0) ? 1 : ((lead < 0) ? 2 : 3);
        end
      end
    end
  endtask

  task automatic add(input int r, input int ini, input int c, input int p, input int s,
                     input int ma, input int pa, input int na,
                     input int mb, input int pb, input int nb);
    vq.push_back('{r, ini, c, p, s, ma, pa, na, mb, pb, nb});
  endtask

  task automatic add2(input int r, input int ini, input int c, input int p, input int s,
                      input int m, input int pa, input int n);
    add(r, ini, c, p, s, m, pa, n, m, pa, n);
  endtask

  initial begin
    // reset, then moves without a start are ignored
    add2(1, 0, 0, 1, 3, 0, 0, 0);
    add2(1, 0, 0, 1, 3, 0, 0, 0);
    add2(0, 0, 0, 1, 3, 0, 0, 0);
    add2(0, 0, 0, 1, 3, 0, 0, 0);
    // P1 sweep, CFG=0
    add2(0, 1, 0, 1, 3, 0, 0, 0);
    add2(0, 0, 0, 1, 3, 1, 0, 1);
    add2(0, 0, 0, 2, 1, 1, 0, 2);
    add2(0, 0, 0, 3, 2, 1, 0, 3);
    add2(0, 0, 0, 1, 3, 1, 1, 4);
    add2(0, 0, 0, 2, 1, 0, 1, 4);
    // no-repeat rule
    add2(0, 1, 0, 0, 0, 0, 0, 0);
    add2(0, 0, 0, 1, 3, 1, 0, 1);
    add (0, 0, 0, 1, 2, 0, 0, 1, 2, 0, 2);
    // draw game, CFG=0
    add2(0, 1, 0, 2, 2, 0, 0, 0);
    add2(0, 0, 0, 2, 2, 3, 0, 1);
    add2(0, 0, 0, 2, 2, 3, 0, 2);
    add2(0, 0, 0, 2, 2, 3, 0, 3);
    add2(0, 0, 0, 2, 2, 3, 3, 4);
    // decision on the manche limit, CFG=2
    add2(0, 1, 2, 0, 0, 0, 0, 0);
    add2(0, 0, 0, 1, 3, 1, 0, 1);
    add2(0, 0, 0, 3, 1, 2, 0, 2);
    add2(0, 0, 0, 1, 3, 1, 0, 3);
    add2(0, 0, 0, 2, 3, 2, 0, 4);
    add2(0, 0, 0, 2, 1, 1, 0, 5);
    add2(0, 0, 0, 3, 3, 3, 1, 6);
    // rst beats INIZIA, restart from END
    add2(1, 1, 3, 1, 3, 0, 0, 0);
    add2(0, 0, 0, 1, 3, 0, 0, 0);
    add2(0, 1, 0, 0, 0, 0, 0, 0);
    add2(0, 0, 0, 1, 3, 1, 0, 1);
    add2(0, 0, 0, 2, 1, 1, 0, 2);
    add2(0, 0, 0, 3, 2, 1, 0, 3);
    add2(0, 0, 0, 1, 3, 1, 1, 4);
    add2(0, 1, 0, 1, 3, 0, 0, 0);
    add2(0, 0, 0, 1, 3, 1, 0, 1);
    add2(0, 0, 0, 0, 3, 0, 0, 1);
    add2(1, 0, 0, 1, 3, 0, 0, 0);

    rst = 1'b1; inizia = 1'b0; cfg = 4'd0; primo = 2'd0; secondo = 2'd0;

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].r[0];
      inizia = vq[i].ini[0];
      cfg = 4'(vq[i].cfg);
      primo = 2'(vq[i].p);
      secondo = 2'(vq[i].s);
      @(posedge clk); #1;
      chk($sformatf("vec%0d manche_a", i), int'(manche_a), vq[i].ma);
      chk($sformatf("vec%0d partita_a", i), int'(partita_a), vq[i].pa);
      chk($sformatf("vec%0d num_a", i), int'(num_a), vq[i].na);
      chk($sformatf("vec%0d manche_b", i), int'(manche_b), vq[i].mb);
      chk($sformatf("vec%0d partita_b", i), int'(partita_b), vq[i].pb);
      chk($sformatf("vec%0d num_b", i), int'(num_b), vq[i].nb);
      $display("vec %0d rst=%0d ini=%0d cfg=%0d %0dv%0d -> A %0d/%0d/%0d B %0d/%0d/%0d",
               i, vq[i].r, vq[i].ini, vq[i].cfg, vq[i].p, vq[i].s,
               manche_a, partita_a, num_a, manche_b, partita_b, num_b);
    end

    for (int c = 0; c < 600; c++) begin
      int r, ini, cf, p, s, pick;
      r = (c == 0 || $urandom_range(0, 63) == 0) ? 1 : 0;
      if (m_phase[0] != 1 && m_phase[1] != 1)
        ini = ($urandom_range(0, 1) == 0) ? 1 : 0;
      else
        ini = ($urandom_range(0, 39) == 0) ? 1 : 0;
      cf = $urandom_range(0, 15);
      pick = $urandom_range(0, 7);
      p = (pick == 0) ? 0 : 1 + (pick % 3);
      pick = $urandom_range(0, 7);
      s = (pick == 0) ? 0 : 1 + (pick % 3);
      rst = r[0]; inizia = ini[0]; cfg = 4'(cf); primo = 2'(p); secondo = 2'(s);
      @(posedge clk); #1;
      model_step(0, r, ini, cf, p, s);
      model_step(1, r, ini, cf, p, s);
      chk($sformatf("rnd%0d manche_a", c), int'(manche_a), m_man[0]);
      chk($sformatf("rnd%0d partita_a", c), int'(partita_a), m_par[0]);
      chk($sformatf("rnd%0d num_a", c), int'(num_a), m_p1w[0] + m_p2w[0] + m_dr[0]);
      chk($sformatf("rnd%0d manche_b", c), int'(manche_b), m_man[1]);
      chk($sformatf("rnd%0d partita_b", c), int'(partita_b), m_par[1]);
      chk($sformatf("rnd%0d num_b", c), int'(num_b), m_p1w[1] + m_p2w[1] + m_dr[1]);
      $display("rnd %0d rst=%0d ini=%0d cfg=%0d %0dv%0d -> A %0d/%0d/%0d B %0d/%0d/%0d",
               c, r, ini, cf, p, s, manche_a, partita_a, num_a, manche_b, partita_b, num_b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
